ls_gate_bank_filtered: RTL and testbench

//  Parametrised successor to the discrete quad-NAND parts: CHANNELS independent 2-input

---
 rtl/ls_gate_bank_filtered.sv | 162 ++++++++++++++++
 tb/tb_ls_gate_bank_filtered.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ls_gate_bank_filtered.sv
// ============================================================================
// Module   : ls_gate_bank_filtered
// Function : CHANNELS 2-input gates with a selectable function, 2-flop input
//            synchronisers, per-channel stability filters, registered outputs.
//            Optional per-channel edge counters: define GATE_EDGE_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ls_gate_bank_filtered #(
    parameter int CHANNELS    = 4,
    parameter int FILT_CYCLES = 3,
    parameter int CNT_W       = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       a,
    input  logic [CHANNELS-1:0]       b,
    input  logic [2:0]                func_sel,
    input  logic                      func_load,
    output logic                      func_ready,
    output logic [CHANNELS-1:0]       y,
    output logic                      y_valid,
    output logic [CHANNELS-1:0]       y_edge,
    output logic [CHANNELS*CNT_W-1:0] edge_cnt,
    input  logic                      cnt_clr
);

    localparam int FCW = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
    localparam int STW = $clog2(FILT_CYCLES + 3);

    localparam logic [FCW-1:0] c_filt_last = FCW'(FILT_CYCLES - 1);
    localparam logic [STW-1:0] c_stl_load  = STW'(FILT_CYCLES + 2);

    localparam logic [2:0] c_f_nand = 3'b000;
    localparam logic [2:0] c_f_and  = 3'b001;
    localparam logic [2:0] c_f_nor  = 3'b010;
    localparam logic [2:0] c_f_or   = 3'b011;
    localparam logic [2:0] c_f_xor  = 3'b100;
    localparam logic [2:0] c_f_xnor = 3'b101;
    localparam logic [2:0] c_f_na   = 3'b110;
    localparam logic [2:0] c_f_a    = 3'b111;

    logic [CHANNELS-1:0] r_a_s1, r_a_s2, r_b_s1, r_b_s2;
    logic [2:0]          r_func_q;
    logic [STW-1:0]      r_stl;
    logic [CHANNELS-1:0] w_raw;
    logic [CHANNELS-1:0] w_y;
    logic [CHANNELS-1:0] r_y_d;
    logic [CHANNELS-1:0] r_y_edge;
    logic                w_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_s1 <= '0;
            r_a_s2 <= '0;
            r_b_s1 <= '0;
            r_b_s2 <= '0;
        end else begin
            r_a_s1 <= a;
            r_a_s2 <= r_a_s1;
            r_b_s1 <= b;
            r_b_s2 <= r_b_s1;
        end
    end

    always_comb begin
        w_raw = '0;
        case (r_func_q)
            c_f_nand: w_raw = ~(r_a_s2 & r_b_s2);
            c_f_and:  w_raw =   r_a_s2 & r_b_s2;
            c_f_nor:  w_raw = ~(r_a_s2 | r_b_s2);
            c_f_or:   w_raw =   r_a_s2 | r_b_s2;
            c_f_xor:  w_raw =   r_a_s2 ^ r_b_s2;
            c_f_xnor: w_raw = ~(r_a_s2 ^ r_b_s2);
            c_f_na:   w_raw = ~r_a_s2;
            c_f_a:    w_raw =  r_a_s2;
            default:  w_raw = '0;
        endcase
    end

    // A result must disagree with y for FILT_CYCLES consecutive clocks to be taken.
    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_filt
            logic [FCW-1:0] r_cnt;
            logic           r_ch_y;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt  <= '0;
                    r_ch_y <= 1'b1;
                end else if (w_raw[i] == r_ch_y) begin
                    r_cnt  <= '0;
                end else if (r_cnt == c_filt_last) begin
                    r_ch_y <= w_raw[i];
                    r_cnt  <= '0;
                end else begin
                    r_cnt  <= r_cnt + 1'b1;
                end
            end

            assign w_y[i] = r_ch_y;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y_d    <= '1;
            r_y_edge <= '0;
        end else begin
            r_y_d    <= w_y;
            r_y_edge <= w_y ^ r_y_d;
        end
    end

    assign w_ready = (r_stl == '0);

    // Settle window covers synchroniser plus filter so y_valid implies y follows func_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_func_q <= c_f_nand;
            r_stl    <= c_stl_load;
        end else if (func_load && w_ready) begin
            r_func_q <= func_sel;
            r_stl    <= c_stl_load;
        end else if (!w_ready) begin
            r_stl    <= r_stl - 1'b1;
        end
    end

    assign y          = w_y;
    assign y_edge     = r_y_edge;
    assign func_ready = w_ready;
    assign y_valid    = w_ready;

`ifdef GATE_EDGE_CNT_EN
    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_ecnt
            logic [CNT_W-1:0] r_ec;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_ec <= '0;
                end else if (cnt_clr) begin
                    r_ec <= '0;
                end else if (r_y_edge[i] && (r_ec != {CNT_W{1'b1}})) begin
                    r_ec <= r_ec + 1'b1;
                end
            end

            assign edge_cnt[i*CNT_W +: CNT_W] = r_ec;
        end
    endgenerate
`else
    logic w_unused_cnt_clr;
    assign w_unused_cnt_clr = cnt_clr;
    assign edge_cnt         = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ls_gate_bank_filtered.sv
// ============================================================================
// Module   : tb_ls_gate_bank_filtered
// Function : Directed self-checking bench for ls_gate_bank_filtered.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ls_gate_bank_filtered;

    localparam int CHANNELS    = 4;
    localparam int FILT_CYCLES = 3;
    localparam int CNT_W       = 2;
`ifdef GATE_EDGE_CNT_EN
    localparam bit HAS_CNT = 1'b1;
`else
    localparam bit HAS_CNT = 1'b0;
`endif

    logic                      clk = 1'b0;
    logic                      rst;
    logic [CHANNELS-1:0]       a, b;
    logic [2:0]                func_sel;
    logic                      func_load;
    logic                      func_ready;
    logic [CHANNELS-1:0]       y;
    logic                      y_valid;
    logic [CHANNELS-1:0]       y_edge;
    logic [CHANNELS*CNT_W-1:0] edge_cnt;
    logic                      cnt_clr;

    int n_checks = 0;
    int n_errors = 0;

    ls_gate_bank_filtered #(
        .CHANNELS   (CHANNELS),
        .FILT_CYCLES(FILT_CYCLES),
        .CNT_W      (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .func_sel  (func_sel),
        .func_load (func_load),
        .func_ready(func_ready),
        .y         (y),
        .y_valid   (y_valid),
        .y_edge    (y_edge),
        .edge_cnt  (edge_cnt),
        .cnt_clr   (cnt_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ready(input string tag, input int exp_n);
        int n = 0;
        while (!func_ready && n < 20) begin
            step(1);
            n++;
        end
        check(tag, n, exp_n);
    endtask

    task automatic load_func(input logic [2:0] f);
        check("ready_before_load", func_ready, 1'b1);
        func_sel  = f;
        func_load = 1'b1;
        step(1);
        func_load = 1'b0;
        check("ready_drop", func_ready, 1'b0);
        wait_ready("load_settle", 5);
    endtask

    logic [3:0] sweep_exp [8] = '{4'b1110, 4'b0001, 4'b1000, 4'b0111,
                                  4'b0110, 4'b1001, 4'b1100, 4'b0011};
    logic [3:0] acc;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; a = '0; b = '0; func_sel = 3'b000; func_load = 1'b0; cnt_clr = 1'b0;
        step(2);
        check("rst_y", y, 4'b1111);
        check("rst_valid", y_valid, 1'b0);
        check("rst_ready", func_ready, 1'b0);
        check("rst_yedge", y_edge, 4'b0000);
        check("rst_ecnt", edge_cnt, '0);
        rst = 1'b0;
        wait_ready("rel_ready", 5);
        check("rel_valid", y_valid, 1'b1);

        // NAND latency on channel 0
        a = 4'b0001; b = 4'b0001;
        step(4);
        check("lat_y_early", y[0], 1'b1);
        step(1);
        check("lat_y_fall", y[0], 1'b0);
        check("lat_edge_early", y_edge, 4'b0000);
        step(1);
        check("lat_edge", y_edge, 4'b0001);
        step(1);
        check("lat_edge_done", y_edge, 4'b0000);

        // two-clock glitch on b[2] must not reach y[2]
        a = 4'b0101;
        step(6);
        b = 4'b0101;
        acc = '0;
        for (int i = 0; i < 2; i++) begin step(1); acc |= y_edge; end
        b = 4'b0001;
        for (int i = 0; i < 8; i++) begin step(1); acc |= y_edge; end
        check("glitch_y", y, 4'b1110);
        check("glitch_edge", acc, 4'b0000);

        // function sweep
        a = 4'b0011; b = 4'b0101;
        step(6);
        for (int f = 0; f < 8; f++) begin
            load_func(3'(f));
            check($sformatf("sweep_y_f%0d", f), y, sweep_exp[f]);
            check("sweep_valid", y_valid, 1'b1);
        end

        // second request while busy is dropped
        func_sel = 3'b010; func_load = 1'b1;
        step(1);
        check("hs_busy1", func_ready, 1'b0);
        func_sel = 3'b100;
        step(2);
        check("hs_busy2", func_ready, 1'b0);
        func_load = 1'b0;
        step(2);
        check("hs_busy3", func_ready, 1'b0);
        step(1);
        check("hs_ready", func_ready, 1'b1);
        check("hs_y_nor", y, 4'b1000);

        // asynchronous reset mid-run with y=0101
        a = 4'b0101; b = 4'b0000;
        step(6);
        load_func(3'b111);
        check("pre_rst_y", y, 4'b0101);
        rst = 1'b1;
        #1;
        check("mid_rst_y", y, 4'b1111);
        check("mid_rst_valid", y_valid, 1'b0);
        check("mid_rst_ready", func_ready, 1'b0);
        step(1);
        rst = 1'b0;
        wait_ready("mid_rel_ready", 5);
        check("post_rst_y", y, 4'b1111);

        // edge counter on channel 1 (func A)
        load_func(3'b111);
        step(4);
        cnt_clr = 1'b1;
        step(1);
        cnt_clr = 1'b0;
        check("ecnt_cleared", edge_cnt, '0);
        for (int t = 0; t < 5; t++) begin
            a = a ^ 4'b0010;
            step(8);
            if (t == 1) check("ecnt_2", edge_cnt[1*CNT_W +: CNT_W], HAS_CNT ? 2 : 0);
        end
        check("ecnt_sat", edge_cnt[1*CNT_W +: CNT_W], HAS_CNT ? 3 : 0);
        check("ecnt_other", edge_cnt[0 +: CNT_W], 0);
        a = a ^ 4'b0010;
        begin
            int n = 0;
            while (!y_edge[1] && n < 12) begin step(1); n++; end
        end
        check("ecnt_edge_seen", y_edge[1], 1'b1);
        cnt_clr = 1'b1;
        step(1);
        cnt_clr = 1'b0;
        check("ecnt_clr_pri", edge_cnt[1*CNT_W +: CNT_W], 0);
        step(2);
        check("ecnt_clr_hold", edge_cnt, '0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
